poly_sample_player: RTL and testbench

Multi-voice SRAM sample playback engine for the synth sampler. It reads one 16-bit PCM word per active voice from external asynchronous SRAM on every sample tick, mixes the words with saturation, and presents one mixed word to the DAC data mux. Each keycode byte selects a sample slot, so up to VOICES keys sound at once. Playback per voice is either one-shot or looped, chosen by a mode input.

---
 rtl/poly_sample_player.sv | 268 ++++++++++++++++++++++++++
 tb/tb_poly_sample_player.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_sample_player.sv
// poly_sample_player
// Multi-voice sample playback engine. On each accepted sample_tick it latches
// the keycodes, reads one PCM word per voice from asynchronous SRAM (address =
// {key, offset}), sums the active voices into a wide accumulator, saturates the
// sum to DATA_W bits and presents it on audio_out with a one-cycle audio_valid.
// Frame length is fixed: 3 + VOICES*(READ_CYCLES+1) cycles including the busy
// tail, whatever the number of active voices.
//
// Ports:
//   Clk          system clock
//   Reset_n      asynchronous active-low reset
//   sample_tick  one-cycle strobe that starts a mix frame
//   keycode      one KEY_W key per voice, 0 = no key
//   loop_mode    per-voice mode, 1 = loop, 0 = one-shot
//   sram_rdata   SRAM read data
//   sram_addr    SRAM address, held outside read phases
//   sram_oe_n    SRAM output enable, active low
//   audio_out    saturated mix, held until the next frame
//   audio_valid  one-cycle pulse when audio_out updates
//   busy         high while a frame is in progress
//   voice_active per-voice playing flags
//   overrun      sticky: a tick arrived while busy
module poly_sample_player #(
   parameter int VOICES      = 4,
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 20,
   parameter int KEY_W       = 8,
   parameter int SLOT_LOG2   = 12,
   parameter int READ_CYCLES = 2
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic                      sample_tick,
   input  logic [VOICES*KEY_W-1:0]   keycode,
   input  logic [VOICES-1:0]         loop_mode,
   input  logic [DATA_W-1:0]         sram_rdata,
   output logic [ADDR_W-1:0]         sram_addr,
   output logic                      sram_oe_n,
   output logic [DATA_W-1:0]         audio_out,
   output logic                      audio_valid,
   output logic                      busy,
   output logic [VOICES-1:0]         voice_active,
   output logic                      overrun
);

   localparam int VIDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
   localparam int CNT_W  = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;
   localparam int ACC_W  = DATA_W + $clog2(VOICES);

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(2 ** (DATA_W - 1));
   localparam logic [SLOT_LOG2-1:0]    OFF_LAST   = {SLOT_LOG2{1'b1}};
   localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(READ_CYCLES - 1);
   localparam logic [VIDX_W-1:0]       VOICE_LAST = VIDX_W'(VOICES - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LATCH = 3'd1,
      ST_RD    = 3'd2,
      ST_ACC   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t                    state_r, state_s;
   logic [VIDX_W-1:0]         voice_r, voice_s;
   logic [CNT_W-1:0]          cnt_r, cnt_s;

   logic [KEY_W-1:0]          key_r [VOICES];
   logic [KEY_W-1:0]          key_s [VOICES];
   logic [SLOT_LOG2-1:0]      off_r [VOICES];
   logic [SLOT_LOG2-1:0]      off_s [VOICES];
   logic [VOICES-1:0]         active_r, active_s;

   logic signed [ACC_W-1:0]   acc_r;
   logic [DATA_W-1:0]         data_r;
   logic [DATA_W-1:0]         sat_s;

   logic [ADDR_W-1:0]         sram_addr_r, addr_s;
   logic                      oe_n_r, oe_n_s;
   logic [DATA_W-1:0]         audio_out_r;
   logic                      audio_valid_r;
   logic                      busy_r;
   logic                      overrun_r;
   logic                      tick_drop_s;

   assign sram_addr    = sram_addr_r;
   assign sram_oe_n    = oe_n_r;
   assign audio_out    = audio_out_r;
   assign audio_valid  = audio_valid_r;
   assign busy         = busy_r;
   assign voice_active = active_r;
   assign overrun      = overrun_r;

   // busy_r still covers the audio_valid cycle, so a tick there is an overrun.
   assign tick_drop_s = sample_tick & ((state_r != ST_IDLE) | busy_r);

   // Frame sequencer: next state, voice index and read-cycle counter.
   always_comb begin
      state_s = state_r;
      voice_s = voice_r;
      cnt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (sample_tick && !busy_r) begin
               state_s = ST_LATCH;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LATCH: begin
            state_s = ST_RD;
            voice_s = {VIDX_W{1'b0}};
            cnt_s   = {CNT_W{1'b0}};
         end
         ST_RD: begin
            if (cnt_r == CNT_LAST) begin
               state_s = ST_ACC;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_ACC: begin
            if (voice_r == VOICE_LAST) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_RD;
               voice_s = voice_r + VIDX_W'(1);
               cnt_s   = {CNT_W{1'b0}};
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
            voice_s = {VIDX_W{1'b0}};
            cnt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Per-voice key/offset/active update: key compare in LATCH, advance in ACC.
   always_comb begin
      key_s    = key_r;
      off_s    = off_r;
      active_s = active_r;
      if (state_r == ST_LATCH) begin
         for (int v = 0; v < VOICES; v++) begin
            key_s[v] = keycode[v*KEY_W +: KEY_W];
            if (key_s[v] == {KEY_W{1'b0}}) begin
               active_s[v] = 1'b0;
               off_s[v]    = {SLOT_LOG2{1'b0}};
            end else if (key_s[v] != key_r[v]) begin
               active_s[v] = 1'b1;
               off_s[v]    = {SLOT_LOG2{1'b0}};
            end else begin
               // same key: a finished one-shot stays silent
               active_s[v] = active_r[v];
               off_s[v]    = off_r[v];
            end
         end
      end else if ((state_r == ST_ACC) && active_r[voice_r]) begin
         if (off_r[voice_r] == OFF_LAST) begin
            off_s[voice_r]    = {SLOT_LOG2{1'b0}};
            active_s[voice_r] = loop_mode[voice_r];
         end else begin
            off_s[voice_r] = off_r[voice_r] + SLOT_LOG2'(1);
         end
      end else begin
         key_s    = key_r;
         off_s    = off_r;
         active_s = active_r;
      end
   end

   // SRAM address/OE for the coming cycle, taken from next-cycle voice state
   // so the address is already valid in the first RD cycle.
   always_comb begin
      addr_s = sram_addr_r;
      oe_n_s = 1'b1;
      if (state_s == ST_RD) begin
         addr_s = ADDR_W'({key_s[voice_s], off_s[voice_s]});
         oe_n_s = ~active_s[voice_s];
      end else begin
         addr_s = sram_addr_r;
         oe_n_s = 1'b1;
      end
   end

   // Saturate the wide accumulator to DATA_W.
   always_comb begin
      sat_s = acc_r[DATA_W-1:0];
      if (acc_r > SAT_MAX) begin
         sat_s = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (acc_r < SAT_MIN) begin
         sat_s = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         sat_s = acc_r[DATA_W-1:0];
      end
   end

   // Sequencer registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r <= ST_IDLE;
         voice_r <= {VIDX_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_s;
         voice_r <= voice_s;
         cnt_r   <= cnt_s;
      end
   end

   // Voice state registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int v = 0; v < VOICES; v++) begin
            key_r[v] <= {KEY_W{1'b0}};
            off_r[v] <= {SLOT_LOG2{1'b0}};
         end
         active_r <= {VOICES{1'b0}};
      end else begin
         key_r    <= key_s;
         off_r    <= off_s;
         active_r <= active_s;
      end
   end

   // Read capture and mix accumulator.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         acc_r  <= {ACC_W{1'b0}};
         data_r <= {DATA_W{1'b0}};
      end else begin
         if ((state_r == ST_RD) && (cnt_r == CNT_LAST)) begin
            data_r <= sram_rdata;
         end
         if (state_r == ST_LATCH) begin
            acc_r <= {ACC_W{1'b0}};
         end else if ((state_r == ST_ACC) && active_r[voice_r]) begin
            acc_r <= acc_r + ACC_W'($signed(data_r));
         end
      end
   end

   // Registered outputs.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sram_addr_r   <= {ADDR_W{1'b0}};
         oe_n_r        <= 1'b1;
         audio_out_r   <= {DATA_W{1'b0}};
         audio_valid_r <= 1'b0;
         busy_r        <= 1'b0;
         overrun_r     <= 1'b0;
      end else begin
         sram_addr_r   <= addr_s;
         oe_n_r        <= oe_n_s;
         audio_valid_r <= (state_r == ST_DONE);
         busy_r        <= (state_s != ST_IDLE) || (state_r == ST_DONE);
         overrun_r     <= overrun_r | tick_drop_s;
         if (state_r == ST_DONE) begin
            audio_out_r <= sat_s;
         end
      end
   end

endmodule

// File: tb/tb_poly_sample_player.sv
// Bench for poly_sample_player: SRAM model, frame-level reference model and
// scenario tasks (reset, timing, one-shot/loop, retrigger, saturation,
// overrun, random).
module tb_poly_sample_player;

   localparam int VOICES      = 4;
   localparam int DATA_W      = 16;
   localparam int ADDR_W      = 20;
   localparam int KEY_W       = 8;
   localparam int SLOT_LOG2   = 12;
   localparam int READ_CYCLES = 2;
   localparam int FRAME_EDGES = 2 + VOICES * (READ_CYCLES + 1);

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b1;
   logic        sample_tick = 1'b0;
   logic [31:0] keycode = 32'h0;
   logic [3:0]  loop_mode = 4'h0;
   logic [15:0] sram_rdata;
   logic [19:0] sram_addr;
   logic        sram_oe_n;
   logic [15:0] audio_out;
   logic        audio_valid;
   logic        busy;
   logic [3:0]  voice_active;
   logic        overrun;

   int total = 0;
   int bad   = 0;

   poly_sample_player #(
      .VOICES(VOICES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .KEY_W(KEY_W),
      .SLOT_LOG2(SLOT_LOG2), .READ_CYCLES(READ_CYCLES)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .sample_tick(sample_tick),
      .keycode(keycode), .loop_mode(loop_mode), .sram_rdata(sram_rdata),
      .sram_addr(sram_addr), .sram_oe_n(sram_oe_n), .audio_out(audio_out),
      .audio_valid(audio_valid), .busy(busy), .voice_active(voice_active),
      .overrun(overrun)
   );

   always #5 Clk = ~Clk;

   // SRAM: either word = addr[15:0], or one fill value per key slot
   logic        fill_mode = 1'b0;
   logic [15:0] fill_tab [256];
   assign sram_rdata = sram_oe_n ? 16'hDEAD :
                       (fill_mode ? fill_tab[sram_addr[19:12]] : sram_addr[15:0]);

   // read monitor: one address per OE-low burst, plus OE-low cycle count
   logic [19:0] rd_q [$];
   int          low_cnt = 0;
   logic        prev_oe = 1'b1;
   always @(negedge Clk) begin
      if (!sram_oe_n) begin
         low_cnt++;
         if (prev_oe) rd_q.push_back(sram_addr);
      end
      prev_oe = sram_oe_n;
   end

   // reference model
   logic [7:0]  mk   [4];
   logic [11:0] moff [4];
   logic [3:0]  mact;
   logic [19:0] exp_q [$];
   logic [15:0] exp_audio;

   localparam logic [7:0]  RT_KEY [6] = '{8'h04, 8'h05, 8'h04, 8'h04, 8'h00, 8'h04};
   localparam logic [19:0] RT_ADR [6] = '{20'h0, 20'h05000, 20'h04000, 20'h04001, 20'h0, 20'h04000};
   localparam logic        RT_ACT [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

   function automatic logic [15:0] word_at(input logic [19:0] a);
      return fill_mode ? fill_tab[a[19:12]] : a[15:0];
   endfunction

   task automatic model_reset();
      for (int v = 0; v < 4; v++) begin
         mk[v] = 8'h00;
         moff[v] = 12'h000;
      end
      mact = 4'h0;
   endtask

   task automatic model_frame();
      int sum;
      logic [7:0] k;
      logic [19:0] a;
      logic signed [15:0] w;
      exp_q.delete();
      sum = 0;
      for (int v = 0; v < 4; v++) begin
         k = keycode[v*8 +: 8];
         if (k == 8'h00) mact[v] = 1'b0;
         else if (k != mk[v]) begin
            mact[v] = 1'b1;
            moff[v] = 12'h000;
         end
         mk[v] = k;
      end
      for (int v = 0; v < 4; v++) begin
         if (mact[v]) begin
            a = {mk[v], moff[v]};
            exp_q.push_back(a);
            w = word_at(a);
            sum += int'(w);
            if (moff[v] == 12'hFFF) begin
               moff[v] = 12'h000;
               mact[v] = loop_mode[v];
            end else begin
               moff[v] = moff[v] + 12'h001;
            end
         end
      end
      if (sum > 32767) exp_audio = 16'h7FFF;
      else if (sum < -32768) exp_audio = 16'h8000;
      else exp_audio = sum[15:0];
   endtask

   // one tick, wait (bounded) for audio_valid, then for busy to drop
   task automatic run_frame(output bit ok, output logic [15:0] aud);
      rd_q.delete();
      low_cnt = 0;
      ok = 1'b0;
      aud = 16'hxxxx;
      @(negedge Clk) sample_tick = 1'b1;
      @(negedge Clk) sample_tick = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (audio_valid === 1'b1) begin
            ok = 1'b1;
            aud = audio_out;
         end else begin
            @(negedge Clk);
         end
      end
      @(negedge Clk);
   endtask

   task automatic test_reset();
      bit ok;
      logic [15:0] aud;
      #2 Reset_n = 1'b0;
      repeat (2) @(negedge Clk);
      total++;
      if ({sram_addr, sram_oe_n, audio_out, audio_valid, busy, voice_active, overrun} !==
          {20'h0, 1'b1, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0}) begin
         bad++;
         $display("FAIL reset_values got addr=%h oe=%b aud=%h v=%b b=%b va=%b ov=%b want 0/1/0/0/0/0/0",
                  sram_addr, sram_oe_n, audio_out, audio_valid, busy, voice_active, overrun);
      end
      Reset_n = 1'b1;
      model_reset();
      keycode = 32'h04;
      run_frame(ok, aud);
      model_frame();
      total++;
      if (aud !== 16'h4000) begin
         bad++;
         $display("FAIL reset_first_frame got=%h want=4000", aud);
      end
      // reset in the middle of a frame
      @(negedge Clk) sample_tick = 1'b1;
      @(negedge Clk) sample_tick = 1'b0;
      repeat (5) @(negedge Clk);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL midframe_busy got=%b want=1", busy);
      end
      Reset_n = 1'b0;
      #1;
      total++;
      if ({sram_addr, sram_oe_n, audio_out, audio_valid, busy, voice_active, overrun} !==
          {20'h0, 1'b1, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0}) begin
         bad++;
         $display("FAIL midframe_reset got addr=%h oe=%b aud=%h v=%b b=%b va=%b ov=%b want 0/1/0/0/0/0/0",
                  sram_addr, sram_oe_n, audio_out, audio_valid, busy, voice_active, overrun);
      end
      @(negedge Clk) Reset_n = 1'b1;
      model_reset();
      run_frame(ok, aud);
      model_frame();
      total++;
      if (ok !== 1'b1 || aud !== 16'h4000 || rd_q.size() != 1 || rd_q[0] !== 20'h04000) begin
         bad++;
         $display("FAIL post_reset_frame ok=%b aud=%h reads=%0d want ok=1 aud=4000 one read at 04000",
                  ok, aud, rd_q.size());
      end
   endtask

   task automatic test_timing();
      logic [15:0] aud;
      aud = 16'hxxxx;
      @(negedge Clk) sample_tick = 1'b1;
      @(posedge Clk);
      #1 sample_tick = 1'b0;
      for (int n = 0; n <= FRAME_EDGES + 2; n++) begin
         if (n > 0) begin
            @(posedge Clk);
            #1;
         end
         total++;
         if (audio_valid !== (n == FRAME_EDGES)) begin
            bad++;
            $display("FAIL valid_timing edge=%0d got=%b want=%b", n, audio_valid, (n == FRAME_EDGES));
         end
         total++;
         if (busy !== (n <= FRAME_EDGES)) begin
            bad++;
            $display("FAIL busy_timing edge=%0d got=%b want=%b", n, busy, (n <= FRAME_EDGES));
         end
         if (n == FRAME_EDGES) aud = audio_out;
      end
      model_frame();
      total++;
      if (aud !== exp_audio) begin
         bad++;
         $display("FAIL timing_audio got=%h want=%h", aud, exp_audio);
      end
   endtask

   task automatic test_oneshot_loop();
      bit ok;
      logic [15:0] aud;
      keycode = 32'h0;
      run_frame(ok, aud);
      model_frame();
      total++;
      if (aud !== 16'h0000 || voice_active !== 4'h0) begin
         bad++;
         $display("FAIL silent_frame aud=%h va=%b want 0000/0000", aud, voice_active);
      end
      keycode = 32'h0000_0104;
      loop_mode = 4'b0010;
      for (int f = 1; f <= 4097; f++) begin
         run_frame(ok, aud);
         model_frame();
         total++;
         if (ok !== 1'b1) begin
            bad++;
            $display("FAIL frame_timeout f=%0d got=%b want=1", f, ok);
         end
         total++;
         if (aud !== exp_audio) begin
            bad++;
            $display("FAIL play_audio f=%0d got=%h want=%h", f, aud, exp_audio);
         end
         total++;
         if (voice_active !== mact) begin
            bad++;
            $display("FAIL play_active f=%0d got=%b want=%b", f, voice_active, mact);
         end
         total++;
         if (low_cnt != exp_q.size() * READ_CYCLES) begin
            bad++;
            $display("FAIL oe_cycles f=%0d got=%0d want=%0d", f, low_cnt, exp_q.size() * READ_CYCLES);
         end
         total++;
         if (rd_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL read_count f=%0d got=%0d want=%0d", f, rd_q.size(), exp_q.size());
         end else begin
            for (int i = 0; i < rd_q.size(); i++) begin
               total++;
               if (rd_q[i] !== exp_q[i]) begin
                  bad++;
                  $display("FAIL read_addr f=%0d i=%0d got=%h want=%h", f, i, rd_q[i], exp_q[i]);
               end
            end
         end
         if (f == 1 || f == 2) begin
            total++;
            if (rd_q.size() == 0 || rd_q[0] !== 20'h04000 + 20'(f - 1)) begin
               bad++;
               $display("FAIL oneshot_start f=%0d reads=%0d want first %h", f, rd_q.size(), 20'h04000 + 20'(f - 1));
            end
         end
         if (f == 4096) begin
            total++;
            if (voice_active[0] !== 1'b0) begin
               bad++;
               $display("FAIL oneshot_end got=%b want=0", voice_active[0]);
            end
         end
         if (f == 4097) begin
            total++;
            if (aud !== 16'h1000 || voice_active !== 4'b0010 || rd_q.size() != 1 || rd_q[0] !== 20'h01000) begin
               bad++;
               $display("FAIL loop_wrap aud=%h va=%b reads=%0d want 1000/0010/one read at 01000",
                        aud, voice_active, rd_q.size());
            end
         end
      end
   endtask

   task automatic test_retrigger();
      bit ok;
      logic [15:0] aud;
      fill_mode = 1'b0;
      loop_mode = 4'h0;
      for (int s = 0; s < 6; s++) begin
         keycode = {24'h0, RT_KEY[s]};
         run_frame(ok, aud);
         model_frame();
         total++;
         if (aud !== exp_audio || voice_active[0] !== RT_ACT[s]) begin
            bad++;
            $display("FAIL retrig_state s=%0d aud=%h va0=%b want %h/%b", s, aud, voice_active[0], exp_audio, RT_ACT[s]);
         end
         if (RT_ACT[s]) begin
            total++;
            if (rd_q.size() == 0 || rd_q[0] !== RT_ADR[s]) begin
               bad++;
               $display("FAIL retrig_addr s=%0d reads=%0d want first %h", s, rd_q.size(), RT_ADR[s]);
            end
         end
      end
   endtask

   task automatic test_saturation();
      bit ok;
      logic [15:0] aud;
      fill_mode = 1'b1;
      for (int k = 1; k <= 4; k++) fill_tab[k] = 16'h7000;
      keycode = 32'h0403_0201;
      run_frame(ok, aud);
      model_frame();
      total++;
      if (aud !== 16'h7FFF || aud !== exp_audio) begin
         bad++;
         $display("FAIL sat_pos got=%h want=7fff", aud);
      end
      for (int k = 1; k <= 4; k++) fill_tab[k] = 16'h9000;
      run_frame(ok, aud);
      model_frame();
      total++;
      if (aud !== 16'h8000 || aud !== exp_audio) begin
         bad++;
         $display("FAIL sat_neg got=%h want=8000", aud);
      end
      fill_tab[1] = 16'h1000;
      fill_tab[2] = 16'hF000;
      keycode = 32'h0000_0201;
      run_frame(ok, aud);
      model_frame();
      total++;
      if (aud !== 16'h0000 || voice_active !== mact) begin
         bad++;
         $display("FAIL sat_cancel aud=%h va=%b want 0000/%b", aud, voice_active, mact);
      end
   endtask

   task automatic test_overrun();
      logic [15:0] aud;
      int extra;
      int n;
      fill_mode = 1'b0;
      keycode = 32'h04;
      total++;
      if (overrun !== 1'b0) begin
         bad++;
         $display("FAIL overrun_clear got=%b want=0", overrun);
      end
      rd_q.delete();
      @(negedge Clk) sample_tick = 1'b1;
      @(posedge Clk);
      #1 sample_tick = 1'b0;
      repeat (4) @(posedge Clk);
      #1 sample_tick = 1'b1;
      @(posedge Clk);
      n = 5;
      #1 sample_tick = 1'b0;
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun_set got=%b want=1", overrun);
      end
      while (n < FRAME_EDGES) begin
         @(posedge Clk);
         n++;
      end
      #1;
      aud = audio_out;
      total++;
      if (audio_valid !== 1'b1) begin
         bad++;
         $display("FAIL overrun_frame_valid got=%b want=1", audio_valid);
      end
      model_frame();
      total++;
      if (aud !== exp_audio) begin
         bad++;
         $display("FAIL overrun_audio got=%h want=%h", aud, exp_audio);
      end
      extra = 0;
      repeat (30) begin
         @(posedge Clk);
         #1 if (audio_valid === 1'b1) extra++;
      end
      total++;
      if (extra != 0 || busy !== 1'b0 || overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun_after extra=%0d busy=%b ov=%b want 0/0/1", extra, busy, overrun);
      end
   endtask

   task automatic test_random();
      bit ok;
      logic [15:0] aud;
      for (int f = 0; f < 40; f++) begin
         for (int v = 0; v < 4; v++) begin
            if ($urandom_range(0, 1) == 0) begin
               keycode[v*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 6));
            end
         end
         loop_mode = 4'($urandom_range(0, 15));
         fill_mode = 1'($urandom_range(0, 1));
         for (int k = 1; k <= 6; k++) fill_tab[k] = 16'($urandom);
         run_frame(ok, aud);
         model_frame();
         total++;
         if (ok !== 1'b1 || aud !== exp_audio) begin
            bad++;
            $display("FAIL rand_audio f=%0d ok=%b got=%h want=%h", f, ok, aud, exp_audio);
         end
         total++;
         if (voice_active !== mact) begin
            bad++;
            $display("FAIL rand_active f=%0d got=%b want=%b", f, voice_active, mact);
         end
         total++;
         if (rd_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_reads f=%0d got=%0d want=%0d", f, rd_q.size(), exp_q.size());
         end else begin
            for (int i = 0; i < rd_q.size(); i++) begin
               total++;
               if (rd_q[i] !== exp_q[i]) begin
                  bad++;
                  $display("FAIL rand_addr f=%0d i=%0d got=%h want=%h", f, i, rd_q[i], exp_q[i]);
               end
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 256; k++) fill_tab[k] = 16'h0000;
      test_reset();
      test_timing();
      test_oneshot_loop();
      test_retrigger();
      test_saturation();
      test_overrun();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
